sword_attack_sequencer: RTL and testbench
=========================================

Name: sword_attack_sequencer

Overview:
- Sequences Link's sword-attack animation and generates sprite ROM addresses for the sword sprite ROM/palette pair in the VGA pipeline.
- Advances animation frames only on frame boundaries, so no frame switches mid-scan (no tearing).
- Computes a per-pixel ROM address and a pixel-enable from DrawX/DrawY against the sprite position, aligned to a 1-cycle synchronous ROM.
- Sits between game logic (attack request, direction, position) and the sword ROM/palette/colour mux.

Parameters:
- NUM_FRAMES, 4, animation frames per attack (1..4).
- FRAME_HOLD, 6, video frames each animation frame is held (>=1).
- COOLDOWN, 8, video frames after the attack during which requests are ignored (0 allowed).
- SPRITE_SIZE, 32, sprite width/height in pixels (power of 2, <=32).

Ports:
- vga_clk  in  1  pixel clock, all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse per video frame (start of vblank).
- attack_req  in  1  attack request, level or pulse.
- dir  in  2  facing: 0=down, 1=up, 2=left, 3=right.
- sprite_x, sprite_y  in  10 each  top-left of sword sprite, screen pixels.
- DrawX, DrawY  in  10 each  current pixel coordinates.
- busy  out  1  high in ACTIVE or COOLDOWN.
- sword_active  out  1  high in ACTIVE only.
- anim_frame  out  2  current animation frame index.
- dir_latched  out  2  direction captured at attack start.
- done  out  1  one-cycle pulse on the ACTIVE->COOLDOWN transition.
- rom_address  out  10  sprite ROM address, registered.
- pix_en  out  1  sword pixel valid, aligned with ROM q.

Behaviour:
- Reset (async assert, sync release): state=IDLE; pending=0; busy, sword_active, anim_frame, dir_latched, done, rom_address, pix_en all 0; hold_cnt=0; cool_cnt=0.
- pending flag:
  - Set by attack_req while in IDLE.
  - Cleared on leaving IDLE.
  - attack_req while ACTIVE/COOLDOWN is dropped, never queued.
- IDLE -> ACTIVE on frame_start when (pending | attack_req), so a request coincident with frame_start starts that frame. On entry: anim_frame=0, hold_cnt=0, dir_latched=dir.
- ACTIVE, on each frame_start:
  - If hold_cnt == FRAME_HOLD-1: hold_cnt=0, then either anim_frame++ or, if anim_frame == NUM_FRAMES-1, go to COOLDOWN with cool_cnt=0 and done=1 for one cycle.
  - Otherwise hold_cnt++.
  - Total ACTIVE duration = NUM_FRAMES*FRAME_HOLD frame_starts.
- COOLDOWN, on each frame_start: if cool_cnt == COOLDOWN-1, go to IDLE; otherwise cool_cnt++. With COOLDOWN=0, ACTIVE goes directly to IDLE (done still pulses).
- State, anim_frame and dir_latched change only in the cycle following a frame_start; they are held at all other times.
- Hit test, computed at 11 bits so there is no wrap:
  - hit = sword_active & DrawX>=sprite_x & DrawX<sprite_x+SPRITE_SIZE & DrawY>=sprite_y & DrawY<sprite_y+SPRITE_SIZE.
  - dx = DrawX-sprite_x; dy = DrawY-sprite_y.
  - When dir_latched==2 (left), dx is mirrored to SPRITE_SIZE-1-dx.
- Address pipeline:
  - Stage 1 (registered): rom_address = dy*SPRITE_SIZE + dx when hit, else 0; hit_r = hit.
  - Stage 2: pix_en = hit_r. pix_en therefore aligns with the ROM q produced from rom_address.
- Latency DrawX/DrawY -> rom_address = 1 cycle; DrawX/DrawY -> pix_en = 2 cycles.
- Edge cases:
  - Sprite partly off-screen (sprite_x > 608): only on-screen pixels hit; no address wrap.
  - reset_n asserted mid-attack returns to IDLE immediately and clears pending.

Test Plan:
1. Reset -> all outputs 0, state IDLE. attack_req pulse mid-frame, then frame_start -> sword_active=1, anim_frame=0 next cycle.
2. Defaults, full attack -> anim_frame 0,1,2,3 each held 6 frame_starts; done pulses once after the 24th frame_start; busy stays high 8 more frame_starts, then 0.
3. attack_req held high during ACTIVE/COOLDOWN -> no restart. The first frame_start after return to IDLE with attack_req still high -> new attack starts.
4. sprite_x=100, sprite_y=200, dir=0, ACTIVE, DrawX=105, DrawY=203 -> rom_address=101 one cycle later, pix_en=1 two cycles later. DrawX=132 -> pix_en=0, rom_address=0.
5. Same pixel with dir=2 latched -> rom_address=3*32+26=122. sprite_x=620, DrawX=639 -> hit with dx=19; DrawX=0 -> no hit.
6. reset_n low for 1 cycle while anim_frame=2 -> immediate IDLE, outputs 0. COOLDOWN=0 build -> IDLE directly after the final frame with done=1.

Source files
------------

// File: rtl/sword_attack_sequencer_if.sv
// Sword sequencer bus: game-logic and raster inputs, animation state and
// ROM-address outputs.
interface sword_attack_sequencer_if;
  logic       frame_start;
  logic       attack_req;
  logic [1:0] dir;
  logic [9:0] sprite_x;
  logic [9:0] sprite_y;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       busy;
  logic       sword_active;
  logic [1:0] anim_frame;
  logic [1:0] dir_latched;
  logic       done;
  logic [9:0] rom_address;
  logic       pix_en;

  modport master (
    output frame_start, attack_req, dir, sprite_x, sprite_y, DrawX, DrawY,
    input  busy, sword_active, anim_frame, dir_latched, done, rom_address, pix_en
  );

  modport slave (
    input  frame_start, attack_req, dir, sprite_x, sprite_y, DrawX, DrawY,
    output busy, sword_active, anim_frame, dir_latched, done, rom_address, pix_en
  );
endinterface

// File: rtl/sword_attack_sequencer.sv
// Sword-attack animation sequencer: frame-boundary state machine plus a
// registered sprite-ROM address / pixel-enable pipeline.
module sword_attack_sequencer #(
  parameter int NUM_FRAMES  = 4,
  parameter int FRAME_HOLD  = 6,
  parameter int COOLDOWN    = 8,
  parameter int SPRITE_SIZE = 32
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  sword_attack_sequencer_if.slave bus
);

  localparam int HW     = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam int CW     = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam int STAGES = 1;

  localparam logic [HW-1:0] HOLD_LAST  = HW'(FRAME_HOLD - 1);
  localparam logic [CW-1:0] COOL_LAST  = CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
  localparam logic [1:0]    FRAME_LAST = 2'(NUM_FRAMES - 1);
  localparam logic [10:0]   SZ         = 11'(SPRITE_SIZE);

  typedef enum logic [1:0] {IDLE, ACTIVE, COOL} state_t;

  state_t        state;
  logic          pending;
  logic [HW-1:0] hold_cnt;
  logic [CW-1:0] cool_cnt;
  logic          busy, sword_active, done;
  logic [1:0]    anim_frame, dir_latched;

  // State only moves on frame_start so the sprite never changes mid-scan.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      pending      <= 1'b0;
      hold_cnt     <= '0;
      cool_cnt     <= '0;
      busy         <= 1'b0;
      sword_active <= 1'b0;
      anim_frame   <= 2'd0;
      dir_latched  <= 2'd0;
      done         <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && bus.attack_req && !bus.frame_start)
        pending <= 1'b1;
      if (bus.frame_start) begin
        case (state)
          IDLE: begin
            if (pending || bus.attack_req) begin
              state        <= ACTIVE;
              pending      <= 1'b0;
              busy         <= 1'b1;
              sword_active <= 1'b1;
              anim_frame   <= 2'd0;
              hold_cnt     <= '0;
              dir_latched  <= bus.dir;
            end
          end
          ACTIVE: begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              if (anim_frame == FRAME_LAST) begin
                done         <= 1'b1;
                sword_active <= 1'b0;
                cool_cnt     <= '0;
                if (COOLDOWN == 0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                end else begin
                  state <= COOL;
                end
              end else begin
                anim_frame <= anim_frame + 2'd1;
              end
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          COOL: begin
            if (cool_cnt == COOL_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cool_cnt <= cool_cnt + 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            busy         <= 1'b0;
            sword_active <= 1'b0;
          end
        endcase
      end
    end
  end

  // Hit test at 11 bits so a sprite hanging off the right/bottom edge cannot wrap.
  logic        hit;
  logic [10:0] dx, dy, dxm;
  logic [9:0]  addr;

  always_comb begin
    dx   = {1'b0, bus.DrawX} - {1'b0, bus.sprite_x};
    dy   = {1'b0, bus.DrawY} - {1'b0, bus.sprite_y};
    dxm  = (dir_latched == 2'd2) ? (SZ - 11'd1 - dx) : dx;
    hit  = sword_active
         && ({1'b0, bus.DrawX} >= {1'b0, bus.sprite_x})
         && ({1'b0, bus.DrawX} <  ({1'b0, bus.sprite_x} + SZ))
         && ({1'b0, bus.DrawY} >= {1'b0, bus.sprite_y})
         && ({1'b0, bus.DrawY} <  ({1'b0, bus.sprite_y} + SZ));
    addr = 10'(dy * SZ) + 10'(dxm);
  end

  logic [9:0]      rom_address;
  logic [STAGES:0] vld_pipe;

  // vld_pipe[0] tracks rom_address; the last stage lines up with ROM q.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_address <= '0;
      vld_pipe    <= '0;
    end else begin
      rom_address <= hit ? addr : '0;
      vld_pipe    <= {vld_pipe[STAGES-1:0], hit};
    end
  end

  assign bus.busy         = busy;
  assign bus.sword_active = sword_active;
  assign bus.anim_frame   = anim_frame;
  assign bus.dir_latched  = dir_latched;
  assign bus.done         = done;
  assign bus.rom_address  = rom_address;
  assign bus.pix_en       = vld_pipe[STAGES];

endmodule

// File: tb/tb_sword_attack_sequencer.sv
// Bench for sword_attack_sequencer: default build plus a COOLDOWN=0 build.
module tb_sword_attack_sequencer;
  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 vga_clk = ~vga_clk;

  sword_attack_sequencer_if ifc();
  sword_attack_sequencer_if ifc0();

  sword_attack_sequencer u_dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (ifc.slave)
  );

  sword_attack_sequencer #(
    .NUM_FRAMES (2),
    .FRAME_HOLD (2),
    .COOLDOWN   (0)
  ) u_dut0 (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (ifc0.slave)
  );

  typedef struct {
    logic [9:0] addr;
    logic       pe;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic frame();
    ifc.frame_start = 1'b1;
    tick();
    ifc.frame_start = 1'b0;
    tick();
  endtask

  function automatic exp_t model(input int x, input int y, input int sx, input int sy,
                                 input int d, input bit act);
    exp_t e;
    int   ddx, ddy;
    ddx  = x - sx;
    ddy  = y - sy;
    e.pe = act && ddx >= 0 && ddx < 32 && ddy >= 0 && ddy < 32;
    if (d == 2) ddx = 31 - ddx;
    e.addr = e.pe ? 10'(ddy * 32 + ddx) : 10'd0;
    return e;
  endfunction

  // Drives one pixel, then checks address after 1 cycle and enable after 2.
  task automatic pix(input int x, input int y, input int d, input bit act);
    exp_t e;
    ifc.DrawX = 10'(x);
    ifc.DrawY = 10'(y);
    sb.push_back(model(x, y, int'(ifc.sprite_x), int'(ifc.sprite_y), d, act));
    tick();
    e = sb.pop_front();
    chk("rom_address", ifc.rom_address, e.addr);
    tick();
    chk("pix_en", ifc.pix_en, e.pe);
  endtask

  initial begin
    ifc.frame_start = 0; ifc.attack_req = 0; ifc.dir = 0;
    ifc.sprite_x = 10'd100; ifc.sprite_y = 10'd200; ifc.DrawX = 0; ifc.DrawY = 0;
    ifc0.frame_start = 0; ifc0.attack_req = 0; ifc0.dir = 0;
    ifc0.sprite_x = 0; ifc0.sprite_y = 0; ifc0.DrawX = 0; ifc0.DrawY = 0;

    // Reset state
    tick(); tick();
    chk("rst_busy", ifc.busy, 0);
    chk("rst_sword", ifc.sword_active, 0);
    chk("rst_anim", ifc.anim_frame, 0);
    chk("rst_dir", ifc.dir_latched, 0);
    chk("rst_done", ifc.done, 0);
    chk("rst_addr", ifc.rom_address, 0);
    chk("rst_pix", ifc.pix_en, 0);
    reset_n = 1'b1;
    tick();

    // Pulse mid-frame is remembered until the next frame_start
    ifc.attack_req = 1; tick(); ifc.attack_req = 0; tick(); tick();
    chk("pend_wait", ifc.sword_active, 0);
    frame();
    chk("start_sword", ifc.sword_active, 1);
    chk("start_anim", ifc.anim_frame, 0);
    chk("start_busy", ifc.busy, 1);

    // Full attack: 24 frame_starts active, done once, 8 cooldown
    for (int k = 1; k <= 24; k++) begin
      ifc.frame_start = 1; tick(); ifc.frame_start = 0;
      chk("done_pulse", ifc.done, k == 24);
      chk("sword_run", ifc.sword_active, k < 24);
      if (k < 24) chk("anim_seq", ifc.anim_frame, k / 6);
      tick();
      chk("done_one", ifc.done, 0);
    end
    for (int k = 1; k <= 8; k++) begin
      frame();
      chk("cool_busy", ifc.busy, k < 8);
    end
    pix(105, 203, 0, 0);

    // Held request never restarts while busy, restarts once idle
    ifc.attack_req = 1;
    frame();
    chk("held_start", ifc.sword_active, 1);
    for (int k = 1; k <= 32; k++) begin
      frame();
      chk("held_sword", ifc.sword_active, k < 24);
      chk("held_busy", ifc.busy, k < 32);
    end
    frame();
    chk("held_restart", ifc.sword_active, 1);
    ifc.attack_req = 0;

    // Address pipeline, dir=0
    pix(105, 203, 0, 1);
    pix(132, 203, 0, 1);
    pix(100, 200, 0, 1);
    pix(131, 231, 0, 1);
    pix(99, 200, 0, 1);
    pix(100, 232, 0, 1);

    // Reset mid-attack at anim_frame 2
    for (int k = 0; k < 12; k++) frame();
    chk("mid_anim", ifc.anim_frame, 2);
    ifc.DrawX = 105; ifc.DrawY = 203;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1;
    chk("mrst_busy", ifc.busy, 0);
    chk("mrst_sword", ifc.sword_active, 0);
    chk("mrst_anim", ifc.anim_frame, 0);
    chk("mrst_addr", ifc.rom_address, 0);
    chk("mrst_pix", ifc.pix_en, 0);
    tick(); reset_n = 1'b1; tick();

    // Reset clears a pending request
    ifc.attack_req = 1; tick(); ifc.attack_req = 0; tick();
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    frame();
    chk("pend_clr", ifc.sword_active, 0);

    // Mirrored sprite and right-edge clipping
    ifc.dir = 2;
    ifc.attack_req = 1; tick(); ifc.attack_req = 0;
    frame();
    ifc.dir = 0;
    chk("dir_latch", ifc.dir_latched, 2);
    pix(105, 203, 2, 1);
    ifc.sprite_x = 10'd620;
    pix(639, 203, 2, 1);
    pix(0, 203, 2, 1);
    pix(651, 203, 2, 1);
    pix(652, 203, 2, 1);

    // COOLDOWN=0 build: ACTIVE straight to IDLE with done
    ifc0.attack_req = 1; tick(); ifc0.attack_req = 0;
    ifc0.frame_start = 1; tick(); ifc0.frame_start = 0; tick();
    chk("c0_start", ifc0.sword_active, 1);
    for (int k = 1; k <= 4; k++) begin
      ifc0.frame_start = 1; tick(); ifc0.frame_start = 0;
      chk("c0_done", ifc0.done, k == 4);
      chk("c0_busy", ifc0.busy, k < 4);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
